// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite definitions: HTRANS encodings and the slave-arbiter
// ownership states. Imported by the arbiter top and its picker.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWNED,
        ARB_BURST,
        ARB_LOCKED
    } arb_state_t;

    // SEQ and BUSY both mean the master is still inside a burst.
    function automatic logic is_seq_busy(input logic [1:0] trans);
        return (trans == HTRANS_SEQ) || (trans == HTRANS_BUSY);
    endfunction

endpackage

// File: rtl/ahb3lite_interconnect_rr_pick.sv
// Round-robin picker: rotate cand so the bit after pointer is at 0,
// find the first set bit, map it back to a master index.
// Ports: cand (requesting candidates), pointer (last owner) ->
//        pick_sel (one-hot winner, 0 if none), pick_idx (binary winner).
module ahb3lite_interconnect_rr_pick #(
    parameter  int MASTERS  = 3,
    localparam int IDX_BITS = MASTERS > 1 ? $clog2(MASTERS) : 1
) (
    input  logic [MASTERS-1:0]  cand,
    input  logic [IDX_BITS-1:0] pointer,
    output logic [MASTERS-1:0]  pick_sel,
    output logic [IDX_BITS-1:0] pick_idx
);

    logic [2*MASTERS-1:0] cand_dbl;
    logic [MASTERS-1:0]   rot;
    logic                 found;
    int                   start;

    always_comb begin
        start    = (int'(pointer) + 1) % MASTERS;
        cand_dbl = {cand, cand};
        rot      = MASTERS'(cand_dbl >> start);
        pick_sel = '0;
        pick_idx = '0;
        found    = 1'b0;
        for (int k = 0; k < MASTERS; k++) begin
            if (rot[k] && !found) begin
                found    = 1'b1;
                pick_idx = IDX_BITS'((start + k) % MASTERS);
                pick_sel = MASTERS'(1) << ((start + k) % MASTERS);
            end
        end
    end

endmodule

// File: rtl/ahb3lite_interconnect_slave_arbiter.sv
// Per-slave-port arbiter: grants the slave to one master at the winning
// priority level and holds it across bursts, locks and wait states.
// Ports: HCLK/HRESET (async, active high), HSEL, priority_i, priority_hi,
//        HTRANS, HMASTLOCK, HREADY -> master_sel, master_idx, gnt_valid,
//        master_wait.
// Option: AHB3LITE_INTERCONNECT_ROUNDROBIN_EN selects round-robin among
//         candidates; otherwise the lowest-index candidate wins.
module ahb3lite_interconnect_slave_arbiter
    import ahb3lite_pkg::*;
#(
    parameter  int MASTERS       = 3,
    localparam int PRIORITY_BITS = $clog2(MASTERS - 1) + 1,
    localparam int IDX_BITS      = MASTERS > 1 ? $clog2(MASTERS) : 1
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic [MASTERS-1:0]               HSEL,
    input  logic [MASTERS*PRIORITY_BITS-1:0] priority_i,
    input  logic [PRIORITY_BITS-1:0]         priority_hi,
    input  logic [2*MASTERS-1:0]             HTRANS,
    input  logic [MASTERS-1:0]               HMASTLOCK,
    input  logic                             HREADY,
    output logic [MASTERS-1:0]               master_sel,
    output logic [IDX_BITS-1:0]              master_idx,
    output logic                             gnt_valid,
    output logic [MASTERS-1:0]               master_wait
);

    arb_state_t          state, nxt_state;
    logic [MASTERS-1:0]  req, cand, active;
    logic [MASTERS-1:0]  pick_sel, nxt_sel;
    logic [IDX_BITS-1:0] pick_idx, nxt_idx;
    logic                pick_lock, nxt_gv;
    logic                own_hsel, own_lock;
    logic [1:0]          own_trans;
    logic                sw, grant, drop;

    always_comb begin
        req    = '0;
        cand   = '0;
        active = '0;
        for (int i = 0; i < MASTERS; i++) begin
            req[i]    = HSEL[i] && (HTRANS[2*i +: 2] == HTRANS_NONSEQ);
            cand[i]   = req[i] &&
                        (priority_i[i*PRIORITY_BITS +: PRIORITY_BITS] == priority_hi);
            active[i] = HSEL[i] && (HTRANS[2*i +: 2] != HTRANS_IDLE);
        end
    end

    // Owner's bus signals; all inactive when nobody owns the port.
    always_comb begin
        own_hsel  = 1'b0;
        own_lock  = 1'b0;
        own_trans = HTRANS_IDLE;
        for (int i = 0; i < MASTERS; i++) begin
            if (master_sel[i]) begin
                own_hsel  = HSEL[i];
                own_lock  = HMASTLOCK[i];
                own_trans = HTRANS[2*i +: 2];
            end
        end
    end

`ifdef AHB3LITE_INTERCONNECT_ROUNDROBIN_EN
    logic [IDX_BITS-1:0] rr_ptr;

    ahb3lite_interconnect_rr_pick #(
        .MASTERS (MASTERS)
    ) u_rr_pick (
        .cand     (cand),
        .pointer  (rr_ptr),
        .pick_sel (pick_sel),
        .pick_idx (pick_idx)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rr_ptr <= IDX_BITS'(MASTERS - 1);
        end else if (grant) begin
            rr_ptr <= pick_idx;
        end
    end
`else
    // Descending scan: the last hit, i.e. the lowest index, wins.
    always_comb begin
        pick_sel = '0;
        pick_idx = '0;
        for (int i = MASTERS - 1; i >= 0; i--) begin
            if (cand[i]) begin
                pick_sel = MASTERS'(1) << i;
                pick_idx = IDX_BITS'(i);
            end
        end
    end
`endif

    assign pick_lock = |(HMASTLOCK & pick_sel);

    always_comb begin
        nxt_state = state;
        nxt_sel   = master_sel;
        nxt_idx   = master_idx;
        nxt_gv    = gnt_valid;
        // Losing HSEL always reopens the window so a faulty owner
        // cannot hang the port.
        sw    = HREADY && ((state == ARB_IDLE) ||
                           ((state == ARB_OWNED) && !own_lock) ||
                           !own_hsel);
        grant = sw && (|cand);
        drop  = sw && !grant && !(own_hsel && is_seq_busy(own_trans));
        if (grant) begin
            nxt_sel   = pick_sel;
            nxt_idx   = pick_idx;
            nxt_gv    = 1'b1;
            nxt_state = pick_lock ? ARB_LOCKED : ARB_OWNED;
        end else if (drop) begin
            nxt_sel   = '0;
            nxt_idx   = '0;
            nxt_gv    = 1'b0;
            nxt_state = ARB_IDLE;
        end else if (HREADY && gnt_valid) begin
            if (own_lock) begin
                nxt_state = ARB_LOCKED;
            end else if (is_seq_busy(own_trans)) begin
                nxt_state = ARB_BURST;
            end else begin
                nxt_state = ARB_OWNED;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state      <= ARB_IDLE;
            master_sel <= '0;
            master_idx <= '0;
            gnt_valid  <= 1'b0;
        end else begin
            state      <= nxt_state;
            master_sel <= nxt_sel;
            master_idx <= nxt_idx;
            gnt_valid  <= nxt_gv;
        end
    end

    assign master_wait = active & ~master_sel;

endmodule

// File: tb/tb_ahb3lite_interconnect_slave_arbiter.sv
// Self-checking bench for the AHB3-Lite slave arbiter: directed vector
// tables, a reset-mid-burst sequence and randomized traffic vs a model.
module tb_ahb3lite_interconnect_slave_arbiter;

    localparam int M  = 3;
    localparam int PB = 2;
    localparam int IB = 2;
`ifdef AHB3LITE_INTERCONNECT_ROUNDROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [M-1:0]  HSEL;
    logic [M*PB-1:0] priority_i;
    logic [PB-1:0] priority_hi;
    logic [2*M-1:0] HTRANS;
    logic [M-1:0]  HMASTLOCK;
    logic          HREADY;
    logic [M-1:0]  master_sel;
    logic [IB-1:0] master_idx;
    logic          gnt_valid;
    logic [M-1:0]  master_wait;

    ahb3lite_interconnect_slave_arbiter #(.MASTERS(M)) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HSEL        (HSEL),
        .priority_i  (priority_i),
        .priority_hi (priority_hi),
        .HTRANS      (HTRANS),
        .HMASTLOCK   (HMASTLOCK),
        .HREADY      (HREADY),
        .master_sel  (master_sel),
        .master_idx  (master_idx),
        .gnt_valid   (gnt_valid),
        .master_wait (master_wait)
    );

    always #5 HCLK = ~HCLK;

    // Stand-in for the priority tree: highest level among selected masters.
    always_comb begin
        priority_hi = '0;
        for (int i = 0; i < M; i++)
            if (HSEL[i] && priority_i[i*PB +: PB] > priority_hi)
                priority_hi = priority_i[i*PB +: PB];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: owner number plus "lock held" / "mid-burst" flags.
    int m_owner;
    bit m_locked;
    bit m_burst;
    int m_ptr;

    function automatic void model_reset();
        m_owner  = -1;
        m_locked = 0;
        m_burst  = 0;
        m_ptr    = M - 1;
    endfunction

    function automatic int tr_of(input int i);
        return int'(HTRANS[2*i +: 2]);
    endfunction

    function automatic bit is_cand(input int j, input int hi);
        return HSEL[j] && tr_of(j) == 2 && int'(priority_i[j*PB +: PB]) == hi;
    endfunction

    task automatic model_step();
        int hi;
        int win;
        bit open;
        bit cont;
        if (!HREADY) return;
        hi   = int'(priority_hi);
        open = (m_owner < 0) || !HSEL[m_owner] ||
               (!m_locked && !m_burst && !HMASTLOCK[m_owner]);
        win  = -1;
        if (open) begin
            for (int k = 1; k <= M; k++) begin
                int j;
                j = RR ? (m_ptr + k) % M : k - 1;
                if (win < 0 && is_cand(j, hi)) win = j;
            end
        end
        cont = (m_owner >= 0) && HSEL[m_owner] &&
               (tr_of(m_owner) == 1 || tr_of(m_owner) == 3);
        if (win >= 0) begin
            m_owner  = win;
            m_locked = HMASTLOCK[win];
            m_burst  = 0;
            m_ptr    = win;
        end else if (open && !cont) begin
            m_owner  = -1;
            m_locked = 0;
            m_burst  = 0;
        end else if (m_owner >= 0) begin
            m_locked = HMASTLOCK[m_owner];
            m_burst  = !HMASTLOCK[m_owner] &&
                       (tr_of(m_owner) == 1 || tr_of(m_owner) == 3);
        end
    endtask

    task automatic check_model(input string tag);
        int es;
        int ew;
        es = (m_owner >= 0) ? (1 << m_owner) : 0;
        ew = 0;
        for (int i = 0; i < M; i++)
            if (HSEL[i] && tr_of(i) != 0) ew |= (1 << i);
        ew &= ~es;
        check({tag, ".m_sel"},  int'(master_sel),  es);
        check({tag, ".m_idx"},  int'(master_idx),  (m_owner >= 0) ? m_owner : 0);
        check({tag, ".m_gv"},   int'(gnt_valid),   (m_owner >= 0) ? 1 : 0);
        check({tag, ".m_wait"}, int'(master_wait), ew);
    endtask

    task automatic advance();
        model_step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [2:0] hs, input logic [5:0] pr,
                         input logic [5:0] tr, input logic [2:0] lk,
                         input logic rdy);
        HSEL       = hs;
        priority_i = pr;
        HTRANS     = tr;
        HMASTLOCK  = lk;
        HREADY     = rdy;
    endtask

    typedef struct {
        logic [2:0] hsel;
        logic [5:0] prio;
        logic [5:0] trans;
        logic [2:0] lock;
        logic       rdy;
        logic [2:0] exp_sel;
        logic [2:0] exp_wait;
    } vec_t;

    function automatic vec_t v(input logic [2:0] hs, input logic [5:0] pr,
                               input logic [5:0] tr, input logic [2:0] lk,
                               input logic rdy, input logic [2:0] es,
                               input logic [2:0] ew);
        vec_t r;
        r.hsel = hs; r.prio = pr; r.trans = tr; r.lock = lk;
        r.rdy = rdy; r.exp_sel = es; r.exp_wait = ew;
        return r;
    endfunction

    task automatic run_vecs(input vec_t q[$], input string tag);
        for (int n = 0; n < q.size(); n++) begin
            drive(q[n].hsel, q[n].prio, q[n].trans, q[n].lock, q[n].rdy);
            @(negedge HCLK);
            check($sformatf("%s%0d.sel", tag, n), int'(master_sel), int'(q[n].exp_sel));
            check($sformatf("%s%0d.wait", tag, n), int'(master_wait), int'(q[n].exp_wait));
            check_model($sformatf("%s%0d", tag, n));
            advance();
        end
    endtask

    vec_t tbl_a[$];
    vec_t tbl_e[$];

    initial begin
        // Priority: M0 prio1, M2 prio2.
        tbl_a.push_back(v(3'b101, 6'b10_00_01, 6'b10_00_10, 3'b000, 1, 3'b000, 3'b101));
        tbl_a.push_back(v(3'b101, 6'b10_00_01, 6'b10_00_10, 3'b000, 1, 3'b100, 3'b001));
        tbl_a.push_back(v(3'b000, 6'b10_00_01, 6'b00_00_00, 3'b000, 1, 3'b100, 3'b000));
        tbl_a.push_back(v(3'b000, 6'b10_00_01, 6'b00_00_00, 3'b000, 1, 3'b000, 3'b000));
        // Burst hold: M1 SEQ x3 while higher-priority M2 waits.
        tbl_a.push_back(v(3'b010, 6'b10_01_00, 6'b00_10_00, 3'b000, 1, 3'b000, 3'b010));
        tbl_a.push_back(v(3'b010, 6'b10_01_00, 6'b00_11_00, 3'b000, 1, 3'b010, 3'b000));
        tbl_a.push_back(v(3'b110, 6'b10_01_00, 6'b10_11_00, 3'b000, 1, 3'b010, 3'b100));
        tbl_a.push_back(v(3'b110, 6'b10_01_00, 6'b10_11_00, 3'b000, 1, 3'b010, 3'b100));
        tbl_a.push_back(v(3'b110, 6'b10_01_00, 6'b10_00_00, 3'b000, 1, 3'b010, 3'b100));
        tbl_a.push_back(v(3'b110, 6'b10_01_00, 6'b10_00_00, 3'b000, 1, 3'b010, 3'b100));
        tbl_a.push_back(v(3'b000, 6'b10_01_00, 6'b00_00_00, 3'b000, 1, 3'b100, 3'b000));
        tbl_a.push_back(v(3'b000, 6'b10_01_00, 6'b00_00_00, 3'b000, 1, 3'b000, 3'b000));
        // Wait states: M0 owns, HREADY low 4 cycles, M1 requests.
        tbl_a.push_back(v(3'b001, 6'b01_01_01, 6'b00_00_10, 3'b000, 1, 3'b000, 3'b001));
        for (int k = 0; k < 4; k++)
            tbl_a.push_back(v(3'b011, 6'b01_01_01, 6'b00_10_10, 3'b000, 0, 3'b001, 3'b010));
        tbl_a.push_back(v(3'b000, 6'b01_01_01, 6'b00_00_00, 3'b000, 1, 3'b001, 3'b000));
        tbl_a.push_back(v(3'b000, 6'b01_01_01, 6'b00_00_00, 3'b000, 1, 3'b000, 3'b000));
        // Lock: M2 locked over 2 NONSEQ, M0 at higher priority waits.
        tbl_a.push_back(v(3'b100, 6'b01_00_10, 6'b10_00_00, 3'b100, 1, 3'b000, 3'b100));
        tbl_a.push_back(v(3'b101, 6'b01_00_10, 6'b10_00_10, 3'b100, 1, 3'b100, 3'b001));
        tbl_a.push_back(v(3'b101, 6'b01_00_10, 6'b00_00_10, 3'b000, 1, 3'b100, 3'b001));
        tbl_a.push_back(v(3'b101, 6'b01_00_10, 6'b00_00_10, 3'b000, 1, 3'b100, 3'b001));
        tbl_a.push_back(v(3'b000, 6'b01_00_10, 6'b00_00_00, 3'b000, 1, 3'b001, 3'b000));
        tbl_a.push_back(v(3'b000, 6'b01_00_10, 6'b00_00_00, 3'b000, 1, 3'b000, 3'b000));
        // Equal-priority contention: round-robin or fixed order.
        tbl_e.push_back(v(3'b111, 6'b0, 6'b10_10_10, 3'b000, 1, 3'b000, 3'b111));
        tbl_e.push_back(v(3'b111, 6'b0, 6'b10_10_10, 3'b000, 1, 3'b001, 3'b110));
        tbl_e.push_back(v(3'b111, 6'b0, 6'b10_10_10, 3'b000, 1,
                          RR ? 3'b010 : 3'b001, RR ? 3'b101 : 3'b110));
        tbl_e.push_back(v(3'b111, 6'b0, 6'b10_10_10, 3'b000, 1,
                          RR ? 3'b100 : 3'b001, RR ? 3'b011 : 3'b110));
        tbl_e.push_back(v(3'b111, 6'b0, 6'b10_10_10, 3'b000, 1, 3'b001, 3'b110));
        tbl_e.push_back(v(3'b000, 6'b0, 6'b00_00_00, 3'b000, 1,
                          RR ? 3'b010 : 3'b001, 3'b000));
        tbl_e.push_back(v(3'b000, 6'b0, 6'b00_00_00, 3'b000, 1, 3'b000, 3'b000));

        // Reset state.
        drive(3'b000, 6'b0, 6'b0, 3'b000, 1'b1);
        HRESET = 1'b1;
        model_reset();
        #2;
        check("rst.sel", int'(master_sel), 0);
        check("rst.idx", int'(master_idx), 0);
        check("rst.gv",  int'(gnt_valid),  0);
        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        run_vecs(tbl_a, "dir");

        // Reset in the middle of an M1 burst.
        drive(3'b010, 6'b0, 6'b00_10_00, 3'b000, 1'b1);
        @(negedge HCLK);
        check_model("mrst.g");
        advance();
        drive(3'b010, 6'b0, 6'b00_11_00, 3'b000, 1'b1);
        @(negedge HCLK);
        check("mrst.own", int'(master_sel), 3'b010);
        check_model("mrst.b");
        advance();
        HRESET = 1'b1;
        model_reset();
        #1;
        check("mrst.sel", int'(master_sel), 0);
        check("mrst.idx", int'(master_idx), 0);
        check("mrst.gv",  int'(gnt_valid),  0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        check("mrst.rel", int'(master_sel), 0);
        check_model("mrst.r");
        advance();
        drive(3'b000, 6'b0, 6'b0, 3'b000, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge HCLK);
            check($sformatf("idle%0d.gv", k), int'(gnt_valid), 0);
            check_model($sformatf("idle%0d", k));
            advance();
        end

        // Fresh pointer for the contention table.
        HRESET = 1'b1;
        model_reset();
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        run_vecs(tbl_e, "rr");

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            logic [5:0] pr;
            logic [2:0] lk;
            for (int i = 0; i < M; i++) pr[i*PB +: PB] = PB'($urandom_range(0, 2));
            for (int i = 0; i < M; i++) lk[i] = ($urandom_range(0, 7) == 0);
            drive(3'($urandom_range(0, 7)), pr, 6'($urandom),
                  lk, ($urandom_range(0, 3) != 0));
            @(negedge HCLK);
            check_model($sformatf("rnd%0d", c));
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
